packet_fifo: RTL and testbench
==============================

# packet_fifo

- Parameterised synchronous FIFO that buffers `packet_t` words between a packet source and a consumer.
- Used as the per-node injection queue in front of each network input port, and as a generic router input buffer.
- Show-ahead (first-word-fall-through): the head entry is always visible on `o_data` while `o_data_val` is high.
- Backpressure runs both ways: `o_en` tells the upstream source there is space, and `i_en` tells the FIFO the downstream port can take the head.

## Interface

Parameters:
- `DEPTH`, default 4 — number of `packet_t` entries; must be ≥ 2; need not be a power of two.

Ports:
- `clk`  in  1 — single clock; all state updates on the rising edge.
- `reset_n`  in  1 — reset, synchronous and active-high; the name follows the codebase convention, the polarity is high.
- `ce`  in  1 — clock enable; when 0, no push or pop occurs.
- `i_data`  in  `$bits(packet_t)` — write data (`packet_t` struct from the shared config).
- `i_data_val`  in  1 — write request.
- `i_en`  in  1 — downstream ready; the head entry is popped when this and `o_data_val` are both 1.
- `o_data`  out  `$bits(packet_t)` — head entry; all-zero when empty.
- `o_data_val`  out  1 — FIFO non-empty.
- `o_en`  out  1 — FIFO not full, so space is available for a write.

## Operation

- State:
  - Storage array of `DEPTH` entries.
  - Write pointer and read pointer, each `$clog2(DEPTH)` bits.
  - Occupancy counter `count`, 0..`DEPTH`, width `$clog2(DEPTH+1)`.
- `push = ce & i_data_val & o_en`
  - A write while full is silently dropped.
  - The upstream must not rely on it being stored.
- `pop = ce & i_en & o_data_val`
  - A pop request while empty is ignored.
- Pointer behaviour:
  - Push: write `i_data` at the write pointer, then advance it.
  - Pop: advance the read pointer.
  - Each pointer wraps from `DEPTH-1` to 0.
- Count update:
  - `push & ~pop`: +1.
  - `pop & ~push`: −1.
  - Both or neither: unchanged.
- Combinational outputs:
  - `o_data_val = (count != 0)`.
  - `o_en = (count != DEPTH)`.
  - `o_data = o_data_val ? mem[rd_ptr] : '0`.
- Simultaneous push and pop:
  - Allowed at any non-empty, non-full occupancy; count is unchanged.
  - When full: push is blocked because `o_en` = 0, pop proceeds, and count becomes `DEPTH-1`.
  - When empty: pop is blocked because `o_data_val` = 0, push proceeds, and count becomes 1.
- `ce` = 0: pointers, count and memory hold; outputs continue to reflect the held state.
- Reset:
  - When `reset_n` = 1 at a rising edge, pointers and count clear to 0, regardless of `ce`, `i_data_val` or `i_en`.
  - Memory contents are not cleared.
  - Data in flight at reset is discarded.
- Data ordering is strictly first-in first-out; packet fields pass through unmodified.

## Timing

- Output values after reset:
  - `o_data_val` = 0.
  - `o_en` = 1.
  - `o_data` = 0.
- Write-to-read latency is 1 cycle: a word pushed at edge N is on `o_data` with `o_data_val` = 1 immediately after edge N.
- Pop takes effect at the edge:
  - The next entry, or zero/invalid if the FIFO becomes empty, appears after that edge.
  - The consumer samples `o_data` in the same cycle it asserts `i_en`.
- `o_en` and `o_data_val` depend only on registered state; there is no combinational path from `i_data_val` or `i_en` to any output.
- Throughput is one push and one pop per cycle sustained.

## Test plan

1. Reset behaviour:
   - Stimulus: assert `reset_n` for 2 cycles with `i_data_val` = 1.
   - Required: `o_data_val` = 0, `o_en` = 1, `o_data` = 0; nothing stored after reset deasserts.
2. Basic ordering and latency:
   - Stimulus: push packets with `x_dest` = 1, 2, 3 on consecutive cycles with `i_en` = 0, then hold `i_en` = 1.
   - Required: `o_data.x_dest` = 1 the cycle after the first push; pops yield 1, 2, 3 in order; `o_data_val` drops after the third pop.
3. Full condition (`DEPTH` = 4):
   - Stimulus: push 5 packets A–E with `i_en` = 0.
   - Required: `o_en` = 0 after the 4th push; E is dropped; draining yields A, B, C, D only.
4. Simultaneous operations:
   - Stimulus a: at full, push and pop in the same cycle. Required: pop occurs, push is dropped, count becomes 3, `o_en` = 1.
   - Stimulus b: at count 2, push and pop in the same cycle. Required: count stays 2 and order is preserved.
5. Wrap-around and throughput:
   - Stimulus: stream 20 packets with `i_en` = 1 continuously.
   - Required: each packet is output one cycle after its push; all 20 arrive in order; count never exceeds 1.
6. Clock enable and mid-operation reset:
   - Stimulus: with 2 entries stored, drive `ce` = 0 with push and pop requested.
   - Required: state unchanged and the head is still visible.
   - Stimulus: then assert `reset_n` with `ce` = 0.
   - Required: FIFO empties, `o_data_val` = 0.

Source files
------------

// File: rtl/packet_fifo.sv
// -----------------------------------------------------------------------------
// packet_fifo
//
// Show-ahead (first-word-fall-through) synchronous FIFO for packet words.
// It is used as the per-node injection queue and as a generic router input
// buffer. The head entry is always visible on o_data while o_data_val is high.
// The upstream source watches o_en for free space. The downstream port raises
// i_en to take the head.
//
// Parameters:
//   DEPTH  number of entries (>= 2, need not be a power of two)
//   WIDTH  packet word width; instantiate with $bits(packet_t)
//
// Ports:
//   clk         in   single clock, rising edge
//   reset_n     in   synchronous, ACTIVE-HIGH reset (legacy name kept)
//   ce          in   clock enable; 0 blocks push and pop
//   i_data      in   write data
//   i_data_val  in   write request (dropped silently when full)
//   i_en        in   downstream ready; pops the head when o_data_val = 1
//   o_data      out  head entry, all-zero when empty
//   o_data_val  out  FIFO non-empty
//   o_en        out  FIFO not full
// -----------------------------------------------------------------------------
module packet_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_data_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_data_val,
  output logic             o_en
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic push;
  logic pop;

  // Flags come only from registered count, so no input reaches an output
  // combinationally.
  assign o_data_val = (count != '0);
  assign o_en       = (count != FULL_CNT);
  assign o_data     = o_data_val ? mem[rd_ptr] : '0;

  // The full/empty gating makes push-at-full and pop-at-empty no-ops.
  assign push = ce & i_data_val & o_en;
  assign pop  = ce & i_en & o_data_val;

  // NOTE: storage has no reset. Pointers and count are the only state that
  // decides validity, so stale words are never observable. Leaving the array
  // unreset lets it map onto plain RAM/register files.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples its pre-edge value, which keeps simulation and the
  // synthesized netlist in agreement.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_packet_fifo.sv
// -----------------------------------------------------------------------------
// tb_packet_fifo
//
// Self-checking bench for packet_fifo (DEPTH = 4). A queue-based reference
// model is checked after every clock. Directed sequences are also checked
// against fixed expected x_dest values. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_packet_fifo;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [3:0]  x_dest;
    logic [3:0]  y_dest;
    logic [1:0]  vc;
    logic [21:0] payload;
  } packet_t;

  localparam int W = $bits(packet_t);

  logic         clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         ce = 1'b0;
  logic [W-1:0] i_data = '0;
  logic         i_data_val = 1'b0;
  logic         i_en = 1'b0;
  logic [W-1:0] o_data;
  logic         o_data_val;
  logic         o_en;

  packet_t head;
  assign head = packet_t'(o_data);

  packet_fifo #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ce         (ce),
    .i_data     (i_data),
    .i_data_val (i_data_val),
    .i_en       (i_en),
    .o_data     (o_data),
    .o_data_val (o_data_val),
    .o_en       (o_en)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] model_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic packet_t pk(input logic [3:0] x);
    packet_t p;
    p.x_dest  = x;
    p.y_dest  = 4'($urandom);
    p.vc      = 2'($urandom);
    p.payload = 22'($urandom);
    return p;
  endfunction

  // Compares every DUT output against the reference queue.
  task automatic check_model();
    check("model_val", 32'(o_data_val), 32'(model_q.size() != 0));
    check("model_en", 32'(o_en), 32'(model_q.size() != DEPTH));
    check("model_data", o_data, (model_q.size() != 0) ? model_q[0] : '0);
  endtask

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cyc(input logic r, input logic c, input logic v, input logic e,
                     input packet_t d);
    logic do_push, do_pop;
    reset_n = r; ce = c; i_data_val = v; i_en = e; i_data = d;
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      do_push = c && v && (model_q.size() < DEPTH);
      do_pop  = c && e && (model_q.size() > 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
    check_model();
  endtask

  task automatic push(input logic [3:0] x);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, pk(x));
  endtask

  task automatic pop();
    cyc(1'b0, 1'b1, 1'b0, 1'b1, pk(4'd0));
  endtask

  // Drains the FIFO, expecting x_dest values lo..hi in order, then empty.
  task automatic drain(input string tag, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      check(tag, 32'(head.x_dest), 32'(k));
      pop();
    end
    check({tag, "_empty"}, 32'(o_data_val), 32'd0);
  endtask

  initial begin
    // 1. Reset with a write request held high.
    cyc(1'b1, 1'b1, 1'b1, 1'b0, pk(4'd9));
    cyc(1'b1, 1'b1, 1'b1, 1'b0, pk(4'd9));
    check("rst_val", 32'(o_data_val), 32'd0);
    check("rst_en", 32'(o_en), 32'd1);
    check("rst_data", o_data, 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, pk(4'd0));
    check("rst_nothing_stored", 32'(o_data_val), 32'd0);

    // 2. Ordering and one-cycle latency.
    push(4'd1);
    check("lat_val", 32'(o_data_val), 32'd1);
    check("lat_head", 32'(head.x_dest), 32'd1);
    push(4'd2);
    push(4'd3);
    drain("order", 1, 3);

    // 3. Full: the fifth write is dropped.
    for (int k = 1; k <= 5; k++) begin
      push(4'(k));
      if (k == 4) check("full_en", 32'(o_en), 32'd0);
    end
    drain("full_drain", 1, 4);

    // 4a. Push + pop at full: pop wins and the push is dropped.
    for (int k = 1; k <= 4; k++) push(4'(k));
    cyc(1'b0, 1'b1, 1'b1, 1'b1, pk(4'd7));
    check("simfull_en", 32'(o_en), 32'd1);
    drain("simfull", 2, 4);

    // 4b. Push + pop at count 2: count and order preserved.
    push(4'd1);
    push(4'd2);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, pk(4'd3));
    drain("sim2", 2, 3);

    // 5. Streaming: each word shows up one cycle after its push.
    for (int k = 1; k <= 20; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b1, pk(4'(k)));
      check("stream_head", 32'(head.x_dest), 32'(k[3:0]));
      check("stream_en", 32'(o_en), 32'd1);
    end
    pop();
    check("stream_empty", 32'(o_data_val), 32'd0);

    // 6. Clock enable hold, then reset with ce low.
    push(4'd1);
    push(4'd2);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk(4'd3));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, pk(4'd4));
    check("ce_head", 32'(head.x_dest), 32'd1);
    check("ce_val", 32'(o_data_val), 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, pk(4'd0));
    check("ce_rst_val", 32'(o_data_val), 32'd0);
    check("ce_rst_data", o_data, 32'd0);

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 63) == 0),
          ($urandom_range(0, 7) != 0),
          1'($urandom),
          1'($urandom),
          pk(4'($urandom)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog: the stimulus is finite, so this only fires if something hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
